// File: rtl/rsa_op_sequencer_if.sv
// Handshake/bus bundle between the top-level input logic and rsa_op_sequencer.
// master = requesting side (start, operands, end_op); slave = sequencer.
interface rsa_op_sequencer_if #(
    parameter int unsigned DW    = 4,
    parameter int unsigned SLOTS = 8
);
    localparam int unsigned PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic                  start;
    logic [SLOTS*DW-1:0]   op_data;
    logic [SLOTS-1:0]      slot_mask;
    logic                  end_op;
    logic                  wr_en;
    logic                  rd_en;
    logic [PTR_W-1:0]      ptr;
    logic [DW-1:0]         inp;
    logic                  upd;
    logic                  busy;
    logic                  done;
    logic                  timeout;

    modport master (
        output start, op_data, slot_mask, end_op,
        input  wr_en, rd_en, ptr, inp, upd, busy, done, timeout
    );

    modport slave (
        input  start, op_data, slot_mask, end_op,
        output wr_en, rd_en, ptr, inp, upd, busy, done, timeout
    );
endinterface

// File: rtl/rsa_op_sequencer.sv
// Sequences seq_system: slot writes, execute/wait for end_op, BCD update strobe.
// Optional EXEC timeout enabled by defining SEQ_TIMEOUT_EN.
module rsa_op_sequencer #(
    parameter int unsigned DW      = 4,
    parameter int unsigned SLOTS   = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic               clk,
    input logic               rst,
    rsa_op_sequencer_if.slave bus
);
    localparam int unsigned PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, EXEC, UPDATE, FINISH} state_t;

    state_t              state, state_nx;
    logic [SLOTS*DW-1:0] data_r, data_nx, src_data;
    logic [SLOTS-1:0]    mask_r, mask_nx, src_mask, rem_mask;
    logic [PTR_W-1:0]    sel, ptr_r, ptr_nx;
    logic [DW-1:0]       inp_r, inp_nx;
    logic                wr_r, wr_nx, rd_r, rd_nx, upd_r, upd_nx;
    logic                done_r, done_nx, busy_r;
    logic                to_hit;

    // The start cycle already issues the first write, so selection reads the raw inputs in IDLE.
    assign src_mask = (state == IDLE) ? bus.slot_mask : mask_r;
    assign src_data = (state == IDLE) ? bus.op_data   : data_r;

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (src_mask[SLOTS-1-i]) sel = PTR_W'(SLOTS-1-i);
        end
        rem_mask = src_mask & ~(SLOTS'(1) << sel);
    end

    always_comb begin
        state_nx = state;
        data_nx  = data_r;
        mask_nx  = mask_r;
        wr_nx    = 1'b0;
        rd_nx    = 1'b0;
        upd_nx   = 1'b0;
        done_nx  = 1'b0;
        ptr_nx   = '0;
        inp_nx   = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    data_nx = bus.op_data;
                    mask_nx = rem_mask;
                    if (bus.slot_mask != '0) begin
                        state_nx = LOAD;
                        wr_nx    = 1'b1;
                        ptr_nx   = sel;
                        inp_nx   = src_data[DW*sel +: DW];
                    end else begin
                        state_nx = EXEC;
                        rd_nx    = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (mask_r != '0) begin
                    wr_nx   = 1'b1;
                    ptr_nx  = sel;
                    inp_nx  = src_data[DW*sel +: DW];
                    mask_nx = rem_mask;
                end else begin
                    state_nx = EXEC;
                    rd_nx    = 1'b1;
                end
            end
            EXEC: begin
                if (bus.end_op) begin
                    state_nx = UPDATE;
                    upd_nx   = 1'b1;
                end else if (to_hit) begin
                    state_nx = FINISH;
                    done_nx  = 1'b1;
                end else begin
                    rd_nx = 1'b1;
                end
            end
            UPDATE: begin
                state_nx = FINISH;
                done_nx  = 1'b1;
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            data_r <= '0;
            mask_r <= '0;
            wr_r   <= 1'b0;
            rd_r   <= 1'b0;
            upd_r  <= 1'b0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
            ptr_r  <= '0;
            inp_r  <= '0;
        end else begin
            state  <= state_nx;
            data_r <= data_nx;
            mask_r <= mask_nx;
            wr_r   <= wr_nx;
            rd_r   <= rd_nx;
            upd_r  <= upd_nx;
            done_r <= done_nx;
            busy_r <= (state_nx != IDLE);
            ptr_r  <= ptr_nx;
            inp_r  <= inp_nx;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_r;
    logic             to_r;

    assign to_hit = (cnt_r == CNT_W'(TIMEOUT - 1));

    // Counter sits at 0 outside EXEC, so it is already cleared on EXEC entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
            to_r  <= 1'b0;
        end else begin
            cnt_r <= (state == EXEC) ? cnt_r + 1'b1 : '0;
            if (state == IDLE && bus.start)
                to_r <= 1'b0;
            else if (state == EXEC && state_nx == FINISH)
                to_r <= 1'b1;
        end
    end

    assign bus.timeout = to_r;
`else
    assign to_hit      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.wr_en = wr_r;
    assign bus.rd_en = rd_r;
    assign bus.ptr   = ptr_r;
    assign bus.inp   = inp_r;
    assign bus.upd   = upd_r;
    assign bus.done  = done_r;
    assign bus.busy  = busy_r;
endmodule

// File: doc/rsa_op_sequencer.md
# rsa_op_sequencer

Controller that sequences the RSA sequential datapath (`seq_system`) without manual switch/button operation. On a start pulse it captures up to eight 4-bit operand nibbles and writes the selected ones into the datapath's register slots, one per clock. It then asserts the read/execute enable and waits for the datapath's end-of-operation flag, with an optional timeout. On completion it pulses the display-update strobe for the BCD stage. It sits between the top-level input logic and `seq_system`/`bcd_32`.

## Interface
Parameters:
- `DW`, 4, operand nibble width (matches datapath `INP`)
- `SLOTS`, 8, number of register slots; `PTR_W` = clog2(`SLOTS`) = 3
- `TIMEOUT`, 1024, maximum cycles to wait for `end_op` (used only with `SEQ_TIMEOUT_EN`)

Ports:
- `clk` in 1 — system clock; one clock domain; all logic on rising edge
- `rst` in 1 — reset, asynchronous, active-high
- `start` in 1 — single-cycle request to begin a sequence
- `op_data` in `SLOTS*DW` — slot i operand = `op_data[DW*i +: DW]`
- `slot_mask` in `SLOTS` — bit i set → write slot i
- `end_op` in 1 — datapath end-of-operation flag
- `wr_en` out 1 — datapath write enable (`WR_EN`)
- `rd_en` out 1 — datapath read/execute enable (`RD_EN`)
- `ptr` out `PTR_W` — datapath slot pointer (`main_ptr`)
- `inp` out `DW` — datapath write data (`INP`)
- `upd` out 1 — one-cycle update strobe to BCD stage
- `busy` out 1 — high whenever state ≠ IDLE
- `done` out 1 — one-cycle completion pulse
- `timeout` out 1 — sticky error flag; cleared on next accepted `start`

## Operation
- States: IDLE, LOAD, EXEC, UPDATE, FINISH.
- IDLE: `start`=1 → latch `op_data` and `slot_mask` into internal registers, clear `timeout`; go to LOAD if latched mask ≠ 0, else EXEC.
- LOAD: each cycle, select lowest set bit i of the remaining mask; drive `ptr`=i, `inp`=nibble i, `wr_en`=1; clear bit i. When the remaining mask becomes 0, the next state is EXEC. Clear bits cost zero cycles; writes are strictly ascending by slot.
- EXEC: `rd_en`=1, `ptr`=0, `wr_en`=0. `end_op` sampled high → UPDATE. Timeout reached (macro enabled) → FINISH with `timeout` set.
- UPDATE: `upd`=1 for one cycle → FINISH.
- FINISH: `done`=1 for one cycle → IDLE.
- `start` while `busy`: ignored; no re-latch, no queueing.
- `end_op` already high on EXEC entry is accepted in the first EXEC cycle.
- `end_op` and timeout expiry in the same cycle: `end_op` wins (normal UPDATE path, `timeout` stays 0).
- Latched operands are immune to `op_data`/`slot_mask` changes after the start cycle.
- Outputs are registered. `inp`/`ptr` hold 0 outside LOAD/EXEC.

## Timing
- Reset (async assert, any state): state=IDLE; `wr_en`, `rd_en`, `upd`, `done`, `busy`, `timeout` = 0; `ptr`=0, `inp`=0; latched registers and timeout counter = 0. Mid-sequence reset aborts immediately; no `upd`/`done` is issued.
- `start` sampled at edge 0 → `busy`=1 and first `wr_en` visible after edge 0 (cycle 1).
- With N set mask bits, `wr_en` is high for exactly N consecutive cycles (1..N). `rd_en` rises at cycle N+1.
- If `end_op` is sampled high at cycle E: `rd_en` falls and `upd`=1 at cycle E+1; `done`=1 at cycle E+2; `busy`=0 at cycle E+3.
- Minimum sequence (mask 0, `end_op` already high): `rd_en` at 1, `upd` at 2, `done` at 3.
- Timeout counter: 0 on EXEC entry, increments each EXEC cycle. When the count reaches `TIMEOUT`−1 without `end_op`, the next cycle is FINISH with `timeout`=1. `rd_en` is high for exactly `TIMEOUT` cycles, and `upd` is not pulsed.

## Configuration
- `SEQ_TIMEOUT_EN` defined: timeout counter and `timeout` flag implemented as above.
- Not defined: no counter; EXEC waits indefinitely for `end_op`; `timeout` tied to 0; `TIMEOUT` unused.

## Test plan
- Reset mid-LOAD (mask 8'hFF, assert `rst` at cycle 3) → all outputs 0 in the same cycle; `done` never pulses; next `start` runs normally.
- `op_data`=32'h87654321, mask 8'b1010_0101, `end_op` high 4 cycles after `rd_en` rises → writes (ptr,inp) = (0,1),(2,3),(5,6),(7,8) in cycles 1–4; `rd_en` cycles 5–9; `upd` at 10; `done` at 11.
- Mask 0 with `end_op` held high → no `wr_en`; `rd_en` at 1, `upd` at 2, `done` at 3.
- `start` pulsed again during EXEC with different `op_data` → ignored; no extra writes; single `done`.
- `SEQ_TIMEOUT_EN`, `TIMEOUT`=16, `end_op` held 0 → `rd_en` high 16 cycles, `timeout`=1 and `done`=1 with no `upd`; `timeout` is cleared by the next `start`.
- `SEQ_TIMEOUT_EN`, `end_op` rises in the final timeout cycle → `upd` pulses, `timeout` stays 0.
